// File: rtl/poly_eval_pkg.sv
// Shared types and constants for the Horner polynomial evaluator.
// FSM state encodings, the degree ceiling and the load-index width helper.
package poly_eval_pkg;

    typedef enum logic [1:0] {
        S_LOAD,
        S_LOAD_WAIT,
        S_CALC,
        S_DONE
    } state_t;

    localparam int MAX_DEGREE = 7;

    // Wide enough to address DEGREE+2 load slots at the maximum degree.
    function automatic int idx_width();
        return $clog2(MAX_DEGREE + 2);
    endfunction

endpackage

// File: rtl/poly_eval_if.sv
// Load/result bus of the polynomial evaluator: Go/DataIn in, result and status out.
// The master side is the switch/key layer, the slave side is the evaluator.
interface poly_eval_if #(
    parameter int WIDTH = 8
);
    logic             Go;
    logic [WIDTH-1:0] DataIn;
    logic [WIDTH-1:0] DataResult;
    logic             Busy;
    logic             Done;
    logic             Overflow;

    modport master (
        output Go,
        output DataIn,
        input  DataResult,
        input  Busy,
        input  Done,
        input  Overflow
    );

    modport slave (
        input  Go,
        input  DataIn,
        output DataResult,
        output Busy,
        output Done,
        output Overflow
    );
endinterface

// File: rtl/poly_mac_step.sv
// One Horner step, acc*x + c, with overflow detection on the full-width sum.
// Build option POLY_EVAL_SATURATE_EN clamps overflowing steps to all-ones instead of wrapping.
module poly_mac_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] result,
    output logic             overflow
);
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH:0]   sum;

    assign prod     = (2*WIDTH)'(acc) * (2*WIDTH)'(x);
    assign sum      = {1'b0, prod} + (2*WIDTH+1)'(c);
    assign overflow = |sum[2*WIDTH:WIDTH];

`ifdef POLY_EVAL_SATURATE_EN
    assign result = overflow ? '1 : sum[WIDTH-1:0];
`else
    assign result = sum[WIDTH-1:0];
`endif

endmodule

// File: rtl/poly_eval_horner.sv
// Serially loaded polynomial evaluator using Horner's method, one multiply-add per cycle.
// Optional clamping of overflowing steps is selected with POLY_EVAL_SATURATE_EN.
//
//   state        | meaning
//   S_LOAD       | waiting for Go=1 to capture the next slot
//   S_LOAD_WAIT  | value captured, waiting for Go=0
//   S_CALC       | one Horner step per cycle, DEGREE cycles
//   S_DONE       | one-cycle Done pulse, result valid
module poly_eval_horner
    import poly_eval_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DEGREE = 2
) (
    input  logic        Clock,
    input  logic        Reset,
    poly_eval_if.slave  bus
);
    localparam int             IW         = idx_width();
    localparam logic [IW-1:0]  LAST_IDX   = IW'(DEGREE + 1);
    localparam logic [IW-1:0]  FIRST_STEP = IW'(DEGREE - 1);

    if (DEGREE < 1 || DEGREE > MAX_DEGREE) begin : g_bad_degree
        $error("poly_eval_horner: DEGREE out of range 1..7");
    end

    state_t           state, state_next;
    logic [IW-1:0]    idx;
    logic [IW-1:0]    step;
    logic [WIDTH-1:0] slot [DEGREE+2];
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] c_cur;
    logic [WIDTH-1:0] mac_out;
    logic             overflow;
    logic             mac_ovf;
    logic             load_en;
    logic             idx_inc;
    logic             calc_start;
    logic             calc_en;

    always_ff @(posedge Clock) begin
        if (Reset) state <= S_LOAD;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        load_en    = 1'b0;
        idx_inc    = 1'b0;
        calc_start = 1'b0;
        calc_en    = 1'b0;
        case (state)
            S_LOAD: begin
                if (bus.Go) begin
                    load_en    = 1'b1;
                    state_next = S_LOAD_WAIT;
                end
            end
            S_LOAD_WAIT: begin
                if (!bus.Go) begin
                    if (idx < LAST_IDX) begin
                        idx_inc    = 1'b1;
                        state_next = S_LOAD;
                    end else begin
                        calc_start = 1'b1;
                        state_next = S_CALC;
                    end
                end
            end
            S_CALC: begin
                calc_en = 1'b1;
                if (step == '0) state_next = S_DONE;
            end
            S_DONE:  state_next = S_LOAD;
            default: state_next = S_LOAD;
        endcase
    end

    // Slot 0 holds c_DEGREE, so step k reads slot DEGREE-k.
    always_comb begin
        c_cur = '0;
        for (int i = 0; i <= DEGREE; i++) begin
            if (step == IW'(DEGREE - i)) c_cur = slot[i];
        end
    end

    poly_mac_step #(.WIDTH(WIDTH)) u_mac (
        .acc      (acc),
        .x        (slot[DEGREE+1]),
        .c        (c_cur),
        .result   (mac_out),
        .overflow (mac_ovf)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            idx      <= '0;
            step     <= '0;
            acc      <= '0;
            result   <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < DEGREE + 2; i++) slot[i] <= '0;
        end else begin
            if (load_en) begin
                for (int i = 0; i < DEGREE + 2; i++) begin
                    if (idx == IW'(i)) slot[i] <= bus.DataIn;
                end
            end
            if (idx_inc) idx <= idx + IW'(1);
            if (calc_start) begin
                idx      <= '0;
                acc      <= slot[0];
                overflow <= 1'b0;
                step     <= FIRST_STEP;
            end
            if (calc_en) begin
                acc      <= mac_out;
                overflow <= overflow | mac_ovf;
                if (step == '0) result <= mac_out;
                else            step   <= step - IW'(1);
            end
        end
    end

    assign bus.DataResult = result;
    assign bus.Overflow   = overflow;
    assign bus.Busy       = (state == S_CALC);
    assign bus.Done       = (state == S_DONE);

endmodule

// File: tb/tb_poly_eval_horner.sv
// Scoreboard bench for poly_eval_horner: an 8-bit quadratic and a 16-bit cubic instance.
// Stimulus pushes expected results; negedge monitors pop and compare on each Done.
module tb_poly_eval_horner;

    typedef struct {
        logic [15:0] res;
        logic        ovf;
    } sb_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_tests = 0;
    int n_fail  = 0;

    sb_t q8[$];
    sb_t q16[$];
    logic [15:0] vals [5];

    always #5 clk = ~clk;

    poly_eval_if #(.WIDTH(8))  bus8 ();
    poly_eval_if #(.WIDTH(16)) bus16 ();

    poly_eval_horner #(.WIDTH(8), .DEGREE(2)) u8 (
        .Clock (clk),
        .Reset (rst),
        .bus   (bus8)
    );

    poly_eval_horner #(.WIDTH(16), .DEGREE(3)) u16 (
        .Clock (clk),
        .Reset (rst),
        .bus   (bus16)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_in(input int u, input logic go, input logic [15:0] d);
        if (u == 0) begin
            bus8.Go     = go;
            bus8.DataIn = d[7:0];
        end else begin
            bus16.Go     = go;
            bus16.DataIn = d;
        end
    endtask

    function automatic logic get_done(input int u);
        return (u == 0) ? bus8.Done : bus16.Done;
    endfunction

    function automatic logic get_busy(input int u);
        return (u == 0) ? bus8.Busy : bus16.Busy;
    endfunction

    task automatic pulse(input int u, input logic [15:0] d, input int hold);
        @(negedge clk);
        set_in(u, 1'b1, d);
        repeat (hold) @(negedge clk);
        set_in(u, 1'b0, d);
    endtask

    // Loads vals[0..degree+1], then measures Done latency; optionally pulses Go mid-compute.
    task automatic run(input int u, input int degree, input logic [15:0] exp_res,
                       input logic exp_ovf, input bit calc_go, input int first_hold);
        sb_t e;
        int  lat;
        e.res = exp_res;
        e.ovf = exp_ovf;
        if (u == 0) q8.push_back(e);
        else        q16.push_back(e);
        for (int i = 0; i < degree + 2; i++) pulse(u, vals[i], (i == 0) ? first_hold : 1);
        lat = 0;
        for (int n = 1; n <= 50; n++) begin
            @(negedge clk);
            if (n == 1) check($sformatf("busy_calc_u%0d", u), 32'(get_busy(u)), 32'd1);
            if (calc_go && n == 1) set_in(u, 1'b1, 16'd99);
            if (calc_go && n == 2) set_in(u, 1'b0, 16'd99);
            if (get_done(u)) begin
                lat = n;
                break;
            end
        end
        check($sformatf("done_latency_u%0d", u), 32'(lat), 32'(degree + 1));
    endtask

    always @(negedge clk) begin
        sb_t e;
        if (bus8.Done) begin
            if (q8.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL u8_unexpected_done: got Done=1 expected no pending result");
            end else begin
                e = q8.pop_front();
                check("u8_result", 32'(bus8.DataResult), 32'(e.res[7:0]));
                check("u8_overflow", 32'(bus8.Overflow), 32'(e.ovf));
            end
        end
        if (bus16.Done) begin
            if (q16.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL u16_unexpected_done: got Done=1 expected no pending result");
            end else begin
                e = q16.pop_front();
                check("u16_result", 32'(bus16.DataResult), 32'(e.res));
                check("u16_overflow", 32'(bus16.Overflow), 32'(e.ovf));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        set_in(0, 1'b0, 16'd0);
        set_in(1, 1'b0, 16'd0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_result", 32'(bus8.DataResult), 32'd0);
        check("rst_busy", 32'(bus8.Busy), 32'd0);
        check("rst_done", 32'(bus8.Done), 32'd0);
        check("rst_overflow", 32'(bus8.Overflow), 32'd0);
        check("rst_result_u16", 32'(bus16.DataResult), 32'd0);
        rst = 1'b0;

        vals = '{16'd2, 16'd3, 16'd4, 16'd5, 16'd0};
        run(0, 2, 16'd69, 1'b0, 1'b0, 1);

        vals = '{16'd10, 16'd0, 16'd0, 16'd10, 16'd0};
`ifdef POLY_EVAL_SATURATE_EN
        run(0, 2, 16'd255, 1'b1, 1'b0, 1);
`else
        run(0, 2, 16'd232, 1'b1, 1'b0, 1);
`endif

        // Abort a load after two coefficients; outputs must clear and indexing restart.
        pulse(0, 16'd2, 1);
        pulse(0, 16'd3, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midload_rst_result", 32'(bus8.DataResult), 32'd0);
        check("midload_rst_overflow", 32'(bus8.Overflow), 32'd0);
        check("midload_rst_busy", 32'(bus8.Busy), 32'd0);
        check("midload_rst_done", 32'(bus8.Done), 32'd0);
        vals = '{16'd2, 16'd3, 16'd4, 16'd5, 16'd0};
        run(0, 2, 16'd69, 1'b0, 1'b0, 1);

        // Long Go hold on the first value, plus a stray Go pulse while computing.
        run(0, 2, 16'd69, 1'b0, 1'b1, 20);

        vals = '{16'd1, 16'd0, 16'd0, 16'd0, 16'd256};
`ifdef POLY_EVAL_SATURATE_EN
        run(1, 3, 16'd65535, 1'b1, 1'b0, 1);
`else
        run(1, 3, 16'd0, 1'b1, 1'b0, 1);
`endif
        vals = '{16'd1, 16'd0, 16'd0, 16'd1, 16'd3};
        run(1, 3, 16'd28, 1'b0, 1'b0, 1);
        vals = '{16'd0, 16'd0, 16'd0, 16'd7, 16'd9};
        run(1, 3, 16'd7, 1'b0, 1'b0, 1);

        repeat (5) @(negedge clk);
        check("sb8_drained", 32'(q8.size()), 32'd0);
        check("sb16_drained", 32'(q16.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
